// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads a combinational word-addressed instruction memory,
// and registers the returned word into IF/ID. Latency 1 edge; a decode stall holds PC and IF/ID.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_WORDS = 16,
   parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [31:0] fetch_count,
   output logic        fault
);

   localparam logic [31:0] MEM_BYTES   = 32'(MEM_WORDS * 4);
   localparam logic        RESET_LEGAL = (RESET_PC[1:0] == 2'b00) && (RESET_PC < MEM_BYTES);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] count_q, count_d;
   logic        fault_q, fault_d;

   // Carry out of the adder marks wrap-around, which is never a legal next PC.
   logic [32:0] pc_sum;
   logic        next_legal;
   logic        target_legal;

   assign pc_sum       = {1'b0, pc_q} + 33'd4;
   assign next_legal   = !pc_sum[32] && (pc_sum[31:0] < MEM_BYTES);
   assign target_legal = (redirect_target[1:0] == 2'b00) && (redirect_target < MEM_BYTES);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      count_d = count_q;
      fault_d = fault_q;
      unique case (state_q)
         BOOT: begin
            if (RESET_LEGAL) begin
               state_d = RUN;
            end else begin
               state_d = FAULT;
               fault_d = 1'b1;
            end
         end
         RUN: begin
            if (redirect_valid) begin
               valid_d = 1'b0;
               instr_d = NOP_WORD;
               if (target_legal) begin
                  pc_d = redirect_target;
               end else begin
                  state_d = FAULT;
                  fault_d = 1'b1;
               end
            end else if (!stall) begin
               instr_d = imem_data;
               pc4_d   = pc_sum[31:0];
               valid_d = 1'b1;
               count_d = count_q + 32'd1;
               // The last word is still delivered; the fault takes effect after it.
               if (next_legal) begin
                  pc_d = pc_sum[31:0];
               end else begin
                  state_d = FAULT;
                  fault_d = 1'b1;
               end
            end
         end
         FAULT: begin
            valid_d = 1'b0;
         end
         default: begin
            state_d = FAULT;
            fault_d = 1'b1;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         instr_q <= NOP_WORD;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
         count_q <= 32'd0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         count_q <= count_d;
         fault_q <= fault_d;
      end
   end

   assign imem_addr   = pc_q;
   assign if_id_instr = instr_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;
   assign fetch_count = count_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 16-word memory holding 0x1000_0000+i.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'd0;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic [31:0] fetch_count;
   logic        fault;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .if_id_instr     (if_id_instr),
      .if_id_pc4       (if_id_pc4),
      .if_id_valid     (if_id_valid),
      .fetch_count     (fetch_count),
      .fault           (fault)
   );

   always #5 clk = ~clk;

   assign imem_data = (imem_addr < 32'd64 && imem_addr[1:0] == 2'b00)
                      ? (32'h1000_0000 + {28'd0, imem_addr[5:2]}) : 32'hDEAD_BEEF;

   function automatic logic [31:0] word(input int i);
      return 32'h1000_0000 + 32'(i);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset asserted between edges; released away from any edge, leaving the DUT in BOOT.
   task automatic do_reset();
      #3 rst_n = 1'b0;
      #1 rst_n = 1'b1;
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_addr", imem_addr, 32'h0);
      check("rst_instr", if_id_instr, 32'h0);
      check("rst_pc4", if_id_pc4, 32'h0);
      check("rst_valid", {31'd0, if_id_valid}, 32'd0);
      check("rst_count", fetch_count, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      #1 rst_n = 1'b1;

      // BOOT: redirect ignored, no capture
      redirect_valid = 1'b1; redirect_target = 32'h30;
      tick();
      redirect_valid = 1'b0;
      check("boot_addr", imem_addr, 32'h0);
      check("boot_valid", {31'd0, if_id_valid}, 32'd0);

      // Free run 4 cycles
      for (int i = 0; i < 4; i++) begin
         tick();
         check("run_instr", if_id_instr, word(i));
         check("run_pc4", if_id_pc4, 32'(4 * (i + 1)));
         check("run_valid", {31'd0, if_id_valid}, 32'd1);
      end
      check("run_count", fetch_count, 32'd4);
      check("run_addr", imem_addr, 32'h10);

      // Stall at PC=0x8
      do_reset();
      tick();
      tick();
      tick();
      check("pre_stall_addr", imem_addr, 32'h8);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_addr", imem_addr, 32'h8);
         check("stall_instr", if_id_instr, word(1));
         check("stall_pc4", if_id_pc4, 32'h8);
         check("stall_count", fetch_count, 32'd2);
      end
      stall = 1'b0;
      tick();
      check("unstall_instr", if_id_instr, word(2));
      check("unstall_pc4", if_id_pc4, 32'hC);
      check("unstall_count", fetch_count, 32'd3);

      // Redirect overrides stall
      stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h20;
      tick();
      stall = 1'b0; redirect_valid = 1'b0;
      check("redir_addr", imem_addr, 32'h20);
      check("redir_valid", {31'd0, if_id_valid}, 32'd0);
      check("redir_instr", if_id_instr, 32'h0);
      check("redir_count", fetch_count, 32'd3);
      tick();
      check("redir_cap_instr", if_id_instr, word(8));
      check("redir_cap_pc4", if_id_pc4, 32'h24);
      check("redir_cap_count", fetch_count, 32'd4);

      // Misaligned redirect -> sticky fault
      redirect_valid = 1'b1; redirect_target = 32'h22;
      tick();
      check("mis_fault", {31'd0, fault}, 32'd1);
      check("mis_valid", {31'd0, if_id_valid}, 32'd0);
      check("mis_addr", imem_addr, 32'h24);
      redirect_target = 32'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("frz_addr", imem_addr, 32'h24);
         check("frz_fault", {31'd0, fault}, 32'd1);
         check("frz_count", fetch_count, 32'd4);
      end
      redirect_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      check("frz_rst_addr", imem_addr, 32'h0);
      check("frz_rst_fault", {31'd0, fault}, 32'd0);
      rst_n = 1'b1;

      // Free run to the end of memory
      tick();
      for (int i = 0; i < 16; i++) begin
         tick();
         check("end_instr", if_id_instr, word(i));
      end
      check("end_pc4", if_id_pc4, 32'h40);
      check("end_valid", {31'd0, if_id_valid}, 32'd1);
      check("end_fault", {31'd0, fault}, 32'd1);
      tick();
      check("post_end_valid", {31'd0, if_id_valid}, 32'd0);
      check("post_end_fault", {31'd0, fault}, 32'd1);
      check("post_end_count", fetch_count, 32'd16);
      check("post_end_addr", imem_addr, 32'h3C);

      // Asynchronous reset mid-run at pc=0x18
      do_reset();
      tick();
      for (int i = 0; i < 6; i++) tick();
      check("mid_addr", imem_addr, 32'h18);
      #3 rst_n = 1'b0;
      #1;
      check("async_addr", imem_addr, 32'h0);
      check("async_instr", if_id_instr, 32'h0);
      check("async_pc4", if_id_pc4, 32'h0);
      check("async_valid", {31'd0, if_id_valid}, 32'd0);
      check("async_count", fetch_count, 32'd0);
      rst_n = 1'b1;
      tick();
      check("async_boot_valid", {31'd0, if_id_valid}, 32'd0);
      check("async_boot_count", fetch_count, 32'd0);
      tick();
      check("async_cap_instr", if_id_instr, word(0));
      check("async_cap_pc4", if_id_pc4, 32'h4);
      check("async_cap_valid", {31'd0, if_id_valid}, 32'd1);

      // Out-of-range redirect target
      redirect_valid = 1'b1; redirect_target = 32'h40;
      tick();
      redirect_valid = 1'b0;
      check("oor_fault", {31'd0, fault}, 32'd1);
      check("oor_addr", imem_addr, 32'h4);
      check("oor_valid", {31'd0, if_id_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
